id_ex_stage: RTL and testbench

- ID/EX pipeline register and execute-stage operand front end for the 5-stage pipelined MIPS core; sits directly upstream of the ALU and drives its opcode, a, b and shamt inputs.
- Registers the decode-stage bundle, then resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Translates alu_op/funct into the 4-bit ALU opcode and raises the load-use stall consumed by the PC and IF/ID registers.

---
 rtl/id_ex_if.sv | 68 ++++++
 rtl/id_ex_stage.sv | 145 ++++++++++++++
 tb/tb_id_ex_stage.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | id_ex_if : decode bundle, forwarding sources and ALU-side outputs |
// | Revision : 1.0                                                    |
// +-------------------------------------------------------------------+
interface id_ex_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          flush;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic [4:0]    id_shamt;
  logic [5:0]    id_funct;
  logic [1:0]    id_alu_op;
  logic          id_alu_src;
  logic          id_reg_dst;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          id_reg_write;
  logic          id_mem_to_reg;
  logic          exmem_reg_write;
  logic [RW-1:0] exmem_rd;
  logic [DW-1:0] exmem_result;
  logic          memwb_reg_write;
  logic [RW-1:0] memwb_rd;
  logic [DW-1:0] memwb_data;
  logic [3:0]    alu_opcode;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [4:0]    alu_shamt;
  logic [DW-1:0] store_data;
  logic [RW-1:0] ex_dest_rd;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          ex_reg_write;
  logic          ex_mem_to_reg;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic          load_use_stall;

  modport master (
    output flush, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_shamt, id_funct, id_alu_op, id_alu_src, id_reg_dst,
           id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data,
    input  alu_opcode, alu_a, alu_b, alu_shamt, store_data, ex_dest_rd,
           ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg,
           fwd_a, fwd_b, load_use_stall
  );

  modport slave (
    input  flush, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_shamt, id_funct, id_alu_op, id_alu_src, id_reg_dst,
           id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data,
    output alu_opcode, alu_a, alu_b, alu_shamt, store_data, ex_dest_rd,
           ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg,
           fwd_a, fwd_b, load_use_stall
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | id_ex_stage : ID/EX register, operand forwarding, ALU control     |
// | Revision    : 1.0                                                 |
// +-------------------------------------------------------------------+
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  wire logic clk,
  input  wire logic reset,
  id_ex_if.slave    bus
);
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd8;
  localparam logic [3:0] ALU_DEF = 4'd15;

  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [RW-1:0] ex_rs, ex_rt, ex_rd;
  logic [4:0]    ex_shamt;
  logic [5:0]    ex_funct;
  logic [1:0]    ex_alu_op;
  logic          ex_alu_src, ex_reg_dst;
  logic          ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;

  logic          stall;
  logic          bubble;
  logic [DW-1:0] fwd_rs_val, fwd_rt_val;

  assign stall  = ex_mem_read && (ex_rt != '0) &&
                  ((ex_rt == bus.id_rs) || (ex_rt == bus.id_rt));
  assign bubble = bus.flush || stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_shamt      <= '0;
      ex_funct      <= '0;
      ex_alu_op     <= '0;
      ex_alu_src    <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
    end else begin
      ex_rs_data <= bus.id_rs_data;
      ex_rt_data <= bus.id_rt_data;
      ex_imm     <= bus.id_imm;
      ex_rs      <= bus.id_rs;
      ex_rt      <= bus.id_rt;
      ex_rd      <= bus.id_rd;
      ex_shamt   <= bus.id_shamt;
      ex_funct   <= bus.id_funct;
      // A bubble only needs its control bits cleared; data is don't-care.
      if (bubble) begin
        ex_alu_op     <= '0;
        ex_alu_src    <= 1'b0;
        ex_reg_dst    <= 1'b0;
        ex_mem_read   <= 1'b0;
        ex_mem_write  <= 1'b0;
        ex_reg_write  <= 1'b0;
        ex_mem_to_reg <= 1'b0;
      end else begin
        ex_alu_op     <= bus.id_alu_op;
        ex_alu_src    <= bus.id_alu_src;
        ex_reg_dst    <= bus.id_reg_dst;
        ex_mem_read   <= bus.id_mem_read;
        ex_mem_write  <= bus.id_mem_write;
        ex_reg_write  <= bus.id_reg_write;
        ex_mem_to_reg <= bus.id_mem_to_reg;
      end
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB.
  always_comb begin
    bus.fwd_a  = FWD_RF;
    fwd_rs_val = ex_rs_data;
    if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == ex_rs)) begin
      bus.fwd_a  = FWD_EXMEM;
      fwd_rs_val = bus.exmem_result;
    end else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == ex_rs)) begin
      bus.fwd_a  = FWD_MEMWB;
      fwd_rs_val = bus.memwb_data;
    end
  end

  always_comb begin
    bus.fwd_b  = FWD_RF;
    fwd_rt_val = ex_rt_data;
    if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == ex_rt)) begin
      bus.fwd_b  = FWD_EXMEM;
      fwd_rt_val = bus.exmem_result;
    end else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == ex_rt)) begin
      bus.fwd_b  = FWD_MEMWB;
      fwd_rt_val = bus.memwb_data;
    end
  end

  always_comb begin
    bus.alu_opcode = ALU_DEF;
    unique case (ex_alu_op)
      2'b00: bus.alu_opcode = ALU_ADD;
      2'b01: bus.alu_opcode = ALU_SUB;
      2'b11: bus.alu_opcode = ALU_OR;
      default: begin
        case (ex_funct)
          6'b100000: bus.alu_opcode = ALU_ADD;
          6'b100010: bus.alu_opcode = ALU_SUB;
          6'b100100: bus.alu_opcode = ALU_AND;
          6'b100101: bus.alu_opcode = ALU_OR;
          6'b101010: bus.alu_opcode = ALU_SLT;
          6'b000000: bus.alu_opcode = ALU_SLL;
          default:   bus.alu_opcode = ALU_DEF;
        endcase
      end
    endcase
  end

  assign bus.alu_a          = fwd_rs_val;
  assign bus.alu_b          = ex_alu_src ? ex_imm : fwd_rt_val;
  assign bus.store_data     = fwd_rt_val;
  assign bus.alu_shamt      = ex_shamt;
  assign bus.ex_dest_rd     = ex_reg_dst ? ex_rd : ex_rt;
  assign bus.ex_mem_read    = ex_mem_read;
  assign bus.ex_mem_write   = ex_mem_write;
  assign bus.ex_reg_write   = ex_reg_write;
  assign bus.ex_mem_to_reg  = ex_mem_to_reg;
  assign bus.load_use_stall = stall;
endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// Directed vector bench for id_ex_stage: table of decode bundles plus
// hand-written load-use and flush sequences.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  id_ex_if #(.DW(32), .RW(5)) bus ();
  id_ex_stage #(.DW(32), .RW(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  // ctl = {alu_src, reg_dst, mem_read, mem_write, reg_write, mem_to_reg}
  // e_ctl = {mem_read, mem_write, reg_write, mem_to_reg}
  typedef struct {
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [1:0]  alu_op;
    logic [5:0]  ctl;
    logic        xw;
    logic [4:0]  xrd;
    logic [31:0] xres;
    logic        ww;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic [3:0]  e_op;
    logic [31:0] e_a, e_b, e_sd;
    logic [4:0]  e_dest, e_sh;
    logic [1:0]  e_fa, e_fb;
    logic [3:0]  e_ctl;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_id(input logic [31:0] rs_data, rt_data, imm,
                          input logic [4:0] rs, rt, rd, shamt,
                          input logic [5:0] funct, input logic [1:0] alu_op,
                          input logic [5:0] ctl);
    bus.id_rs_data = rs_data;  bus.id_rt_data = rt_data;  bus.id_imm = imm;
    bus.id_rs = rs;  bus.id_rt = rt;  bus.id_rd = rd;  bus.id_shamt = shamt;
    bus.id_funct = funct;  bus.id_alu_op = alu_op;
    {bus.id_alu_src, bus.id_reg_dst, bus.id_mem_read, bus.id_mem_write,
     bus.id_reg_write, bus.id_mem_to_reg} = ctl;
  endtask

  task automatic set_fwd(input logic xw, input logic [4:0] xrd, input logic [31:0] xres,
                         input logic ww, input logic [4:0] wrd, input logic [31:0] wdat);
    bus.exmem_reg_write = xw;  bus.exmem_rd = xrd;  bus.exmem_result = xres;
    bus.memwb_reg_write = ww;  bus.memwb_rd = wrd;  bus.memwb_data = wdat;
  endtask

  function automatic logic [3:0] ex_ctl();
    return {bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write, bus.ex_mem_to_reg};
  endfunction

  initial begin
    vecs[0]  = '{32'd10, 32'd15, 0, 1, 2, 3, 0, 6'h20, 2, 6'b010010, 0, 0, 0, 0, 0, 0,
                 2, 32'd10, 32'd15, 32'd15, 3, 0, 0, 0, 4'b0010};
    vecs[1]  = '{32'hAAA, 32'hBBB, 0, 5, 5, 9, 0, 6'h22, 2, 6'b010010, 1, 5, 32'h111, 1, 5, 32'h222,
                 6, 32'h111, 32'h111, 32'h111, 9, 0, 2'b10, 2'b10, 4'b0010};
    vecs[2]  = '{32'hAAA, 32'hBBB, 0, 5, 5, 9, 0, 6'h22, 2, 6'b010010, 0, 5, 32'h111, 1, 5, 32'h222,
                 6, 32'h222, 32'h222, 32'h222, 9, 0, 2'b01, 2'b01, 4'b0010};
    vecs[3]  = '{32'hAAA, 32'hBBB, 0, 5, 5, 9, 0, 6'h22, 2, 6'b010010, 1, 0, 32'h111, 1, 0, 32'h222,
                 6, 32'hAAA, 32'hBBB, 32'hBBB, 9, 0, 0, 0, 4'b0010};
    vecs[4]  = '{32'd1, 32'd2, 0, 1, 2, 3, 0, 6'h24, 2, 6'b010010, 0, 0, 0, 0, 0, 0,
                 0, 32'd1, 32'd2, 32'd2, 3, 0, 0, 0, 4'b0010};
    vecs[5]  = '{32'd1, 32'd2, 0, 1, 2, 3, 0, 6'h25, 2, 6'b010010, 0, 0, 0, 0, 0, 0,
                 1, 32'd1, 32'd2, 32'd2, 3, 0, 0, 0, 4'b0010};
    vecs[6]  = '{32'd1, 32'd2, 0, 1, 2, 3, 0, 6'h2A, 2, 6'b010010, 0, 0, 0, 0, 0, 0,
                 7, 32'd1, 32'd2, 32'd2, 3, 0, 0, 0, 4'b0010};
    vecs[7]  = '{32'd0, 32'd2, 0, 0, 2, 3, 4, 6'h00, 2, 6'b010010, 0, 0, 0, 0, 0, 0,
                 8, 32'd0, 32'd2, 32'd2, 3, 4, 0, 0, 4'b0010};
    vecs[8]  = '{32'd1, 32'd2, 0, 1, 2, 3, 0, 6'h3F, 2, 6'b010010, 0, 0, 0, 0, 0, 0,
                 15, 32'd1, 32'd2, 32'd2, 3, 0, 0, 0, 4'b0010};
    vecs[9]  = '{32'h30, 32'h55, 32'd4, 0, 8, 0, 0, 6'h00, 0, 6'b100100, 1, 8, 32'h77, 0, 0, 0,
                 2, 32'h30, 32'd4, 32'h77, 8, 0, 0, 2'b10, 4'b0100};
    vecs[10] = '{32'd1, 32'd2, 0, 3, 6, 0, 0, 6'h00, 1, 6'b000000, 0, 0, 0, 1, 3, 32'h99,
                 6, 32'h99, 32'd2, 32'd2, 6, 0, 2'b01, 0, 4'b0000};
    vecs[11] = '{32'h100, 32'h200, 32'hFFFF_FFF0, 4, 10, 0, 0, 6'h00, 3, 6'b100010,
                 1, 10, 32'h333, 0, 4, 32'hDEAD,
                 1, 32'h100, 32'hFFFF_FFF0, 32'h333, 10, 0, 0, 2'b10, 4'b0010};
    vecs[12] = '{32'd1, 32'd2, 0, 7, 8, 9, 0, 6'h20, 2, 6'b010010, 1, 8, 32'h444, 1, 7, 32'h555,
                 2, 32'h555, 32'h444, 32'h444, 9, 0, 2'b01, 2'b10, 4'b0010};

    // Reset with a live load in ID must leave everything cleared.
    reset = 1'b1;
    bus.flush = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0);
    drive_id(32'h1234, 32'h5678, 32'h9, 5, 5, 7, 3, 6'h22, 2, 6'b111111);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl",    32'(ex_ctl()), 0);
    chk("reset_opcode", 32'(bus.alu_opcode), 2);
    chk("reset_stall",  32'(bus.load_use_stall), 0);
    chk("reset_dest",   32'(bus.ex_dest_rd), 0);
    chk("reset_fwd",    32'({bus.fwd_a, bus.fwd_b}), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive_id(vecs[i].rs_data, vecs[i].rt_data, vecs[i].imm, vecs[i].rs, vecs[i].rt,
               vecs[i].rd, vecs[i].shamt, vecs[i].funct, vecs[i].alu_op, vecs[i].ctl);
      @(posedge clk);
      #1;
      // Park ID on $0 so no load-use match can arise from the table.
      bus.id_rs = 0;
      bus.id_rt = 0;
      set_fwd(vecs[i].xw, vecs[i].xrd, vecs[i].xres, vecs[i].ww, vecs[i].wrd, vecs[i].wdat);
      #1;
      chk($sformatf("v%0d_opcode", i), 32'(bus.alu_opcode), 32'(vecs[i].e_op));
      chk($sformatf("v%0d_alu_a", i),  bus.alu_a, vecs[i].e_a);
      chk($sformatf("v%0d_alu_b", i),  bus.alu_b, vecs[i].e_b);
      chk($sformatf("v%0d_store", i),  bus.store_data, vecs[i].e_sd);
      chk($sformatf("v%0d_dest", i),   32'(bus.ex_dest_rd), 32'(vecs[i].e_dest));
      chk($sformatf("v%0d_shamt", i),  32'(bus.alu_shamt), 32'(vecs[i].e_sh));
      chk($sformatf("v%0d_fwd", i),    32'({bus.fwd_a, bus.fwd_b}), 32'({vecs[i].e_fa, vecs[i].e_fb}));
      chk($sformatf("v%0d_ctl", i),    32'(ex_ctl()), 32'(vecs[i].e_ctl));
      chk($sformatf("v%0d_stall", i),  32'(bus.load_use_stall), 0);
    end

    // Load-use: lw $4 in EX, sub $6,$4,$7 in ID.
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      set_fwd(0, 0, 0, 0, 0, 0);
      drive_id(0, 0, 32'd8, 1, 4, 0, 0, 6'h00, 0, 6'b101011);
      @(posedge clk);
      #1;
      drive_id(32'd3, 32'd4, 0, 4, 7, 6, 0, 6'h22, 2, 6'b010010);
      bus.flush = (pass == 1);
      #1;
      chk($sformatf("lu%0d_stall_on", pass), 32'(bus.load_use_stall), 1);
      chk($sformatf("lu%0d_ex_mr", pass),    32'(bus.ex_mem_read), 1);
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      #1;
      chk($sformatf("lu%0d_bubble_ctl", pass), 32'(ex_ctl()), 0);
      chk($sformatf("lu%0d_bubble_op", pass),  32'(bus.alu_opcode), 2);
      chk($sformatf("lu%0d_stall_off", pass),  32'(bus.load_use_stall), 0);
      @(posedge clk);
      #2;
      chk($sformatf("lu%0d_sub_ctl", pass), 32'(ex_ctl()), 32'(4'b0010));
      chk($sformatf("lu%0d_sub_op", pass),  32'(bus.alu_opcode), 6);
      chk($sformatf("lu%0d_sub_dest", pass), 32'(bus.ex_dest_rd), 6);
    end

    // Reset arriving alongside a flush discards the in-flight store.
    @(negedge clk);
    drive_id(0, 32'h66, 32'd4, 2, 3, 0, 0, 6'h00, 0, 6'b100100);
    bus.flush = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_ctl", 32'(ex_ctl()), 0);
    chk("rst_mid_b",   bus.alu_b, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.flush = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_sw_ctl", 32'(ex_ctl()), 32'(4'b0100));
    chk("post_rst_sw_b",   bus.alu_b, 32'd4);
    chk("post_rst_sw_sd",  bus.store_data, 32'h66);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
